// File: rtl/miinst_issue_queue_pkg.sv
// miinst_issue_queue_pkg: micro-instruction types, slot count and helpers shared by the issue queue
package miinst_issue_queue_pkg;
    localparam int MQ_N = 4;
    typedef enum logic [2:0] {
        MIOP_NOP,
        MIOP_ADDI,
        MIOP_LOAD,
        MIOP_STORE,
        MIOP_JR,
        MIOP_MOVI
    } miop_e;
    typedef struct packed {
        miop_e       op;
        logic [3:0]  rd;
        logic [15:0] imm;
        logic [31:0] pc;
    } miinst_t;
    typedef logic [MQ_N-1:0] slot_mask_t;
    function automatic miinst_t nop();
        return '{op: MIOP_NOP, default: '0};
    endfunction
endpackage

// File: rtl/miinst_slot_pick.sv
// miinst_slot_pick: lowest set slot of a remaining-mask, plus any / exactly-one flags
module miinst_slot_pick import miinst_issue_queue_pkg::*; #(
    parameter int N = MQ_N,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] mask,
    output logic [W-1:0] idx,
    output logic         any,
    output logic         one_hot
);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) idx = mask[i] ? W'(i) : idx;
    end
    assign any     = |mask;
    assign one_hot = $onehot(mask);
endmodule

// File: rtl/miinst_issue_queue.sv
// miinst_issue_queue: buffers decoded micro-op bundles and issues one non-NOP micro-op per cycle
module miinst_issue_queue import miinst_issue_queue_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int MQ_N = miinst_issue_queue_pkg::MQ_N,
    localparam int AW = $clog2(DEPTH),
    localparam int SW = (MQ_N > 1) ? $clog2(MQ_N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          bundle_valid,
    input  miinst_t       bundle [MQ_N],
    output logic          bundle_ready,
    output logic          issue_valid,
    output miinst_t       issue,
    output logic          issue_last,
    input  logic          issue_ready,
    output logic [AW:0]   count
);
    logic [AW-1:0]   head, tail;
    logic [MQ_N-1:0] rem [DEPTH];
    miinst_t         slots [DEPTH][MQ_N];
    logic [MQ_N-1:0] new_rem;
    logic [SW-1:0]   cur;
    logic            any, one_hot, enq, fire, pop;

    miinst_slot_pick #(.N(MQ_N)) u_pick (
        .mask    (rem[head]),
        .idx     (cur),
        .any     (any),
        .one_hot (one_hot)
    );

    always_comb begin
        new_rem = '0;
        for (int i = 0; i < MQ_N; i++) new_rem[i] = bundle[i].op != MIOP_NOP;
    end

    assign bundle_ready = count != (AW+1)'(DEPTH);
    assign issue_valid  = (count != '0) & any;
    assign issue        = issue_valid ? slots[head][cur] : nop();
    assign issue_last   = issue_valid & one_hot;
    // all-NOP bundles are accepted but never occupy an entry
    assign enq          = bundle_valid & bundle_ready & ~flush & (|new_rem);
    assign fire         = issue_valid & issue_ready & ~flush;
    assign pop          = fire & one_hot;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) rem[i] <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (fire & ~one_hot) rem[head][cur] <= 1'b0;
            if (enq) begin
                rem[tail] <= new_rem;
                tail      <= tail + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            count <= count + (AW+1)'(enq) - (AW+1)'(pop);
        end

    always_ff @(posedge clk)
        if (enq) for (int i = 0; i < MQ_N; i++) slots[tail][i] <= bundle[i];
endmodule

// File: tb/tb_miinst_issue_queue.sv
// tb_miinst_issue_queue: directed and random stimulus checked against a queue-of-micro-ops model
module tb_miinst_issue_queue;
    import miinst_issue_queue_pkg::*;
    localparam int DEPTH = 4;

    logic    clk = 0, rst = 1, flush = 0, bundle_valid = 0, issue_ready = 0;
    miinst_t bundle [MQ_N];
    logic    bundle_ready, issue_valid, issue_last;
    miinst_t issue;
    logic [$clog2(DEPTH):0] count;

    int      n_cmp = 0, n_bad = 0, pc_ctr = 1, jr_last = 0;
    miinst_t mq[$];
    int      bq[$];

    always #5 clk = ~clk;

    miinst_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .bundle_valid (bundle_valid),
        .bundle       (bundle),
        .bundle_ready (bundle_ready),
        .issue_valid  (issue_valid),
        .issue        (issue),
        .issue_last   (issue_last),
        .issue_ready  (issue_ready),
        .count        (count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_bundle(input miop_e a, input miop_e b, input miop_e c, input miop_e d);
        miop_e ops [4];
        ops = '{a, b, c, d};
        for (int i = 0; i < MQ_N; i++) begin
            bundle[i] = '{op: ops[i], rd: 4'($urandom), imm: 16'($urandom), pc: 32'(pc_ctr)};
            pc_ctr++;
        end
    endtask

    function automatic miop_e rop();
        return ($urandom_range(0, 4) < 2) ? MIOP_NOP : miop_e'(3'($urandom_range(1, 5)));
    endfunction

    // model: flat list of pending micro-ops plus per-instruction remaining counts
    task automatic tick();
        bit enq, fire;
        int k;
        miinst_t exp_issue;
        chk("count", 64'(count), 64'(bq.size()));
        chk("bundle_ready", 64'(bundle_ready), 64'(bq.size() != DEPTH));
        chk("issue_valid", 64'(issue_valid), 64'(bq.size() != 0));
        exp_issue = (bq.size() != 0) ? mq[0] : nop();
        chk("issue", 64'(issue), 64'(exp_issue));
        chk("issue_last", 64'(issue_last), 64'(bq.size() != 0 && bq[0] == 1));
        enq  = bundle_valid && bq.size() != DEPTH && !flush;
        fire = bq.size() != 0 && issue_ready && !flush;
        @(posedge clk);
        #1;
        if (flush) begin
            mq.delete();
            bq.delete();
        end else begin
            if (fire) begin
                void'(mq.pop_front());
                bq[0] = bq[0] - 1;
                if (bq[0] == 0) void'(bq.pop_front());
            end
            if (enq) begin
                k = 0;
                for (int i = 0; i < MQ_N; i++)
                    if (bundle[i].op != MIOP_NOP) begin
                        mq.push_back(bundle[i]);
                        k++;
                    end
                if (k != 0) bq.push_back(k);
            end
        end
    endtask

    initial begin
        set_bundle(MIOP_NOP, MIOP_NOP, MIOP_NOP, MIOP_NOP);
        #12;
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_ready", 64'(bundle_ready), 64'(1));
        chk("rst_valid", 64'(issue_valid), 64'(0));
        chk("rst_last", 64'(issue_last), 64'(0));
        chk("rst_issue", 64'(issue), 64'(nop()));
        @(posedge clk);
        #1;
        rst = 0;
        tick();

        // PUSH-style bundle
        set_bundle(MIOP_ADDI, MIOP_STORE, MIOP_NOP, MIOP_NOP);
        bundle_valid = 1;
        issue_ready  = 1;
        tick();
        bundle_valid = 0;
        chk("push_op0", 64'(issue.op), 64'(MIOP_ADDI));
        chk("push_last0", 64'(issue_last), 64'(0));
        tick();
        chk("push_op1", 64'(issue.op), 64'(MIOP_STORE));
        chk("push_last1", 64'(issue_last), 64'(1));
        tick();
        chk("push_count", 64'(count), 64'(0));

        // fill with RET-style bundles, 5th is held
        issue_ready  = 0;
        bundle_valid = 1;
        repeat (4) begin
            set_bundle(MIOP_LOAD, MIOP_ADDI, MIOP_JR, MIOP_NOP);
            tick();
        end
        chk("fill_count", 64'(count), 64'(4));
        chk("fill_ready", 64'(bundle_ready), 64'(0));
        set_bundle(MIOP_MOVI, MIOP_MOVI, MIOP_NOP, MIOP_NOP);
        repeat (2) tick();
        bundle_valid = 0;
        issue_ready  = 1;
        repeat (12) begin
            if (issue_valid && issue_last && issue.op == MIOP_JR) jr_last++;
            tick();
        end
        chk("fill_jr_last", 64'(jr_last), 64'(4));
        chk("fill_drained", 64'(count), 64'(0));

        // all-NOP bundle between two MOVI bundles
        issue_ready  = 0;
        bundle_valid = 1;
        set_bundle(MIOP_MOVI, MIOP_NOP, MIOP_NOP, MIOP_NOP);
        tick();
        set_bundle(MIOP_NOP, MIOP_NOP, MIOP_NOP, MIOP_NOP);
        tick();
        chk("nop_count", 64'(count), 64'(1));
        set_bundle(MIOP_NOP, MIOP_NOP, MIOP_MOVI, MIOP_NOP);
        tick();
        chk("nop_count2", 64'(count), 64'(2));
        bundle_valid = 0;
        issue_ready  = 1;
        tick();
        chk("nop_gap", 64'(issue_valid), 64'(1));
        chk("nop_op", 64'(issue.op), 64'(MIOP_MOVI));
        tick();

        // flush with 3 entries held and a simultaneous bundle
        issue_ready  = 0;
        bundle_valid = 1;
        repeat (3) begin
            set_bundle(MIOP_LOAD, MIOP_NOP, MIOP_ADDI, MIOP_NOP);
            tick();
        end
        set_bundle(MIOP_MOVI, MIOP_STORE, MIOP_NOP, MIOP_NOP);
        flush = 1;
        tick();
        flush        = 0;
        bundle_valid = 0;
        chk("flush_count", 64'(count), 64'(0));
        chk("flush_valid", 64'(issue_valid), 64'(0));
        issue_ready = 1;
        repeat (2) tick();

        // simultaneous enqueue and pop at DEPTH-1 across the tail wrap
        issue_ready  = 0;
        bundle_valid = 1;
        repeat (3) begin
            set_bundle(MIOP_MOVI, MIOP_NOP, MIOP_NOP, MIOP_NOP);
            tick();
        end
        issue_ready = 1;
        set_bundle(MIOP_NOP, MIOP_ADDI, MIOP_NOP, MIOP_NOP);
        tick();
        chk("wrap_count", 64'(count), 64'(DEPTH - 1));
        repeat (3) begin
            set_bundle(MIOP_STORE, MIOP_NOP, MIOP_NOP, MIOP_NOP);
            tick();
        end
        bundle_valid = 0;
        repeat (4) tick();
        chk("wrap_drained", 64'(count), 64'(0));

        // asynchronous reset while a micro-op is offered
        issue_ready  = 0;
        bundle_valid = 1;
        set_bundle(MIOP_ADDI, MIOP_JR, MIOP_NOP, MIOP_NOP);
        tick();
        bundle_valid = 0;
        chk("arst_pre_valid", 64'(issue_valid), 64'(1));
        #2;
        rst = 1;
        #1;
        chk("arst_valid", 64'(issue_valid), 64'(0));
        chk("arst_count", 64'(count), 64'(0));
        chk("arst_last", 64'(issue_last), 64'(0));
        chk("arst_issue", 64'(issue), 64'(nop()));
        chk("arst_ready", 64'(bundle_ready), 64'(1));
        mq.delete();
        bq.delete();
        @(posedge clk);
        #1;
        rst = 0;
        tick();

        // random traffic
        repeat (400) begin
            bundle_valid = ($urandom_range(0, 3) != 0);
            issue_ready  = ($urandom_range(0, 2) != 0);
            flush        = ($urandom_range(0, 24) == 0);
            set_bundle(rop(), rop(), rop(), rop());
            tick();
        end
        bundle_valid = 0;
        flush        = 0;
        issue_ready  = 1;
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/miinst_issue_queue.md
# miinst_issue_queue

Buffers the micro-instruction bundles produced by the fetch/decode phase (up to `MQ_N` slots per x86 instruction) and issues them one micro-op per cycle to the execute stage. It sits between the opcode/ModRM/immediate decode path and the execute stage. It drops NOP slots so they never take an issue cycle, and it marks the last micro-op of each x86 instruction. A flush input discards all buffered work on a branch/jump redirect.

## Interface
- `DEPTH`, default 4: number of bundle entries, power of two, at least 2.
- `MQ_N`, default from common params: slots per bundle.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  discard every buffered bundle.
- `bundle_valid`  in  1  decode presents a complete bundle.
- `bundle`  in  `miinst_t [MQ_N]`  slots, indexed 0..MQ_N-1 in program order.
- `bundle_ready`  out  1  queue can accept a bundle this cycle.
- `issue_valid`  out  1  `issue` holds a real micro-op.
- `issue`  out  `miinst_t`  micro-op being offered.
- `issue_last`  out  1  this is the final micro-op of its x86 instruction.
- `issue_ready`  in  1  execute accepts `issue`.
- `count`  out  `$clog2(DEPTH)+1`  occupied entries.

## Operation
- Each entry holds `MQ_N` slots plus a remaining-mask `rem[MQ_N]`. On enqueue, `rem[i] = (bundle[i].op != MIOP_NOP)`.
- Enqueue happens when `bundle_valid & bundle_ready & ~flush`.
  - An all-NOP bundle (`rem == 0`) is accepted but not stored, so `count` does not change.
- `bundle_ready = (count != DEPTH)`. No bypass: a pop in the same cycle does not free space.
- Head slot index `cur` is the lowest set bit of `rem` of the head entry.
- `issue_valid = (count != 0)`.
- `issue = head.slot[cur]`. When `count == 0`, `issue` is `nop` with pc 0.
- `issue_last = issue_valid & (rem of head has exactly one bit set)`.
- Issue handshake fires on `issue_valid & issue_ready & ~flush`:
  - If `issue_last`: pop the head (head pointer +1 mod DEPTH, `count` -1).
  - Otherwise: clear bit `cur` in the head's `rem`.
- Enqueue and pop in the same cycle leave `count` unchanged; the head and tail pointers both advance.
- Flush: `count <= 0`, head and tail pointers `<= 0`.
  - Flush overrides enqueue and issue in the same cycle: the bundle is dropped and no handshake is considered to have fired.
  - Stored slot contents may remain stale; they are never visible because `issue_valid` is 0.
- Pointers wrap modulo DEPTH. `count` saturates logically at DEPTH, which `bundle_ready` guarantees.
- `issue_ready` high while `issue_valid` is 0 has no effect.

## Timing
- Reset (async assert) values: `count=0`, pointers 0, all `rem=0`, `issue_valid=0`, `issue_last=0`, `issue=nop`, `bundle_ready=1`.
- All outputs are combinational from registers only. There is no combinational path from `bundle*`, `flush` or `issue_ready` to any output.
- Enqueue-to-issue latency is 1 cycle: a bundle accepted at edge N is offered from cycle N+1.
- Throughput is one micro-op per cycle. A bundle with k non-NOP slots occupies exactly k issue cycles.
- Execute may hold `issue_ready` low indefinitely; `issue` and `issue_last` stay stable while not accepted and no flush occurs.
- Reset asserted mid-operation clears the queue immediately, including any handshake in that cycle.

## Structure
- Shared package / common params provide `miinst_t`, `MIOP_NOP`, `nop()` and `MQ_N`.
- Add `typedef logic [MQ_N-1:0] slot_mask_t` to the shared package.
- One sub-module, `miinst_slot_pick`: purely combinational.
  - Input: `slot_mask_t`.
  - Outputs: lowest-set index, `any`, and `one_hot` (exactly one bit set).
- Entry storage is a register array; no memory macro is used.

## Test plan
- Reset, then a PUSH-style bundle {ADDI, STORE, NOP, NOP} with `issue_ready=1`:
  - Cycle 1 issues ADDI with last=0.
  - Cycle 2 issues STORE with last=1.
  - `count` returns to 0.
- Fill test: 4 RET-style bundles {LOAD, ADDI, JR, NOP} with `issue_ready=0`:
  - `count=4` and `bundle_ready=0`.
  - A 5th bundle is held.
  - Raising `issue_ready` produces 12 issues in order; `issue_last` is high on each JR.
- All-NOP bundle between two MOVI bundles: accepted, `count` never counts it, and the output sequence is MOVI, MOVI with no gap.
- Flush while holding 3 entries and a simultaneous `bundle_valid`:
  - Next cycle `count=0` and `issue_valid=0`.
  - The flushed-cycle bundle never issues.
- Enqueue and pop in the same cycle at `count=DEPTH-1` with wrap-around:
  - `count` is unchanged.
  - Order is preserved across a tail pointer wrap from 3 to 0.
- Assert `rst` while `issue_valid=1`: outputs go to reset values asynchronously, before the next clock edge.
